morse_key_decoder: RTL
======================

# morse_key_decoder

Parametrised successor to the single-key dot/dash parser. Samples an active-low Morse key, classifies each press by its length in time-base ticks, and packs the symbols of one letter into a code word. Reports letter and word boundaries from the gaps between presses. Sits between the board key/clock divider (`tick` comes from a divided-clock edge) and the downstream letter lookup/HEX display logic.

## Interface
Parameters:
- `DASH_TICKS`, default 3: a press lasting at least this many ticks is a dash; 1..DASH_TICKS-1 ticks is a dot.
- `LETTER_GAP_TICKS`, default 3: released time, in ticks, that closes a letter.
- `WORD_GAP_TICKS`, default 7: released time, in ticks, that flags a word gap. Must be > LETTER_GAP_TICKS.
- `MAX_SYMBOLS`, default 5: symbol capacity of one letter.
- `CNT_W`, default 8: tick counter width. WORD_GAP_TICKS and DASH_TICKS must each be ≤ 2^CNT_W-1.

Ports (clock and reset listed first):
- `Clock` in 1: system clock. This is the block's only clock.
- `Reset` in 1: reset, asynchronous and active-high.
- `tick` in 1: one-cycle time-base strobe.
- `unparsed` in 1: raw key, asynchronous to `Clock`. 0 = pressed, 1 = released.
- `dot` out 1: one-cycle pulse when a press is classified as a dot.
- `dash` out 1: one-cycle pulse when a press is classified as a dash.
- `letter_valid` out 1: one-cycle pulse when a letter closes.
- `letter_code` out MAX_SYMBOLS: packed symbols of the letter. LSB is the first symbol; 1 = dash, 0 = dot; unused bits are 0.
- `letter_len` out $clog2(MAX_SYMBOLS+1): number of symbols stored in the letter.
- `overflow` out 1: set when the letter had more than MAX_SYMBOLS presses.
- `word_gap` out 1: one-cycle pulse when a word gap is detected.

## Operation
- **Input synchronisation.** `unparsed` passes through two flops, both resetting to 1. `pressed` = NOT of the second flop.
- **Tick counter `cnt`.** Increments on `tick`, saturates at 2^CNT_W-1, and clears on every state change.
- **IDLE.** Nothing is pending. On `pressed`, go to PRESS.
- **PRESS.** Count ticks. On release:
  - `cnt`==0: glitch. No pulse, no symbol. Return to GAP if the buffer is non-empty, otherwise IDLE.
  - `cnt` ≥ DASH_TICKS: pulse `dash` and store 1.
  - Otherwise: pulse `dot` and store 0.
  - Storing writes the symbol at bit index `len` and increments `len`.
  - If `len`==MAX_SYMBOLS, the pulse still fires, but the symbol is dropped and the internal overflow flag is set.
  - Go to GAP.
- **GAP.** Count ticks.
  - On `pressed`, go to PRESS. The letter stays open.
  - On the cycle `cnt` reaches LETTER_GAP_TICKS:
    - Latch the buffer, `len` and the overflow flag into `letter_code`, `letter_len` and `overflow`.
    - Pulse `letter_valid`.
    - Clear the internal buffer.
    - Go to WGAP; `cnt` keeps counting and is not cleared on this transition.
- **WGAP.** Count ticks.
  - On `pressed`, go to PRESS with no `word_gap`.
  - When `cnt` reaches WORD_GAP_TICKS, pulse `word_gap` and go to IDLE.
- **Simultaneous events.**
  - Release and `tick` in the same cycle: the release wins and the tick is not counted.
  - In GAP, press and letter threshold in the same cycle: `letter_valid` fires, the buffer clears, and the FSM goes to PRESS.
- **Output holding.** `letter_code`, `letter_len` and `overflow` hold their values until the next `letter_valid`.
- **Reset, including mid-press or mid-gap.** All outputs go to 0. FSM goes to IDLE, `cnt` = 0, buffer is cleared, and both sync flops go to 1. A partial letter is discarded and no pulse fires.

## Timing
- All outputs are registered.
- Edge numbering: let edge N be the edge that first samples a new `unparsed` level.
  - Sync flop 2 holds that level after edge N+1.
  - The FSM acts at edge N+2.
  - `dot`/`dash` are high from edge N+2 to N+3.
- `letter_valid` is high the cycle after the tick that makes `cnt` == LETTER_GAP_TICKS.
- `letter_code`, `letter_len` and `overflow` are valid in that same cycle.
- `word_gap` is high the cycle after the tick that makes `cnt` == WORD_GAP_TICKS.
- `dot`, `dash`, `letter_valid` and `word_gap` are never high for 2 consecutive cycles.

## Structure
- Package `morse_pkg` contains:
  - state typedef {IDLE, PRESS, GAP, WGAP};
  - `SYM_DOT`=1'b0 and `SYM_DASH`=1'b1.
- Sub-module `key_sync`: 2-flop synchroniser; output resets to released (1).
- The FSM, counter and letter buffer live in `morse_key_decoder`.
- Board top instantiates `morse_key_decoder` as follows:
  - `unparsed` = KEY[0];
  - `Reset` = SW[9];
  - `tick` = rising edge of the selected clock-divider bit.

## Test plan
All scenarios use the default parameters with `tick` tied to 1.
- **Reset.** Assert `Reset` while a press is in progress -> all outputs 0 in the same cycle. After release of `Reset`, no `dot`/`dash` is produced for the aborted press.
- **Single dot.** Press 1 tick, then release -> one `dot` pulse. After 3 released ticks: `letter_valid`, `letter_code`=5'b00000, `letter_len`=1, `overflow`=0.
- **Letter "A" (dot, dash).** Press 1 tick, gap 1 tick, press 4 ticks, release -> `dot` then `dash` pulses. `letter_code`=5'b00010, `letter_len`=2.
- **Overflow.** 6 dots separated by 1-tick gaps -> 6 `dot` pulses. `letter_len`=5, `letter_code`=0, `overflow`=1. On the next letter, `overflow`=0.
- **Word gap.**
  - Dot, then release held for 7 ticks -> `letter_valid` at 3 ticks, `word_gap` at 7 ticks, FSM returns to IDLE.
  - Repeat with a press at tick 5 -> no `word_gap`.
- **Glitch and simultaneous events.**
  - Hold `tick` at 0 and toggle the key for 1 cycle -> no pulse.
  - Press landing on the letter-threshold cycle -> `letter_valid` fires, and the new press starts a fresh letter (`letter_len`=1 at the following `letter_valid`).

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key decoder.
//   state_t  : decoder FSM states
//   SYM_DOT  : symbol value stored for a dot
//   SYM_DASH : symbol value stored for a dash
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // nothing pending
    PRESS = 2'd1,  // key held, timing the press
    GAP   = 2'd2,  // key released, letter still open
    WGAP  = 2'd3   // letter closed, waiting to see if a word gap follows
  } state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw Morse key.
// Both flops reset to the released level (1) so that a reset never looks
// like a press to the decoder downstream.
// Ports:
//   Clock    : system clock
//   Reset    : asynchronous active-high reset
//   async_in : raw key, asynchronous to Clock (0 = pressed)
//   sync_out : synchronised key level
module key_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_p0;
  logic sync_p1;

  // Stage 0: first capture, may go metastable.
  // Stage 1: settled copy used by the decoder.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      meta_p0 <= async_in;
      sync_p1 <= meta_p0;
    end
  end

  assign sync_out = sync_p1;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder.
// Samples an active-low key, times each press in `tick` units, classifies it
// as a dot or dash, packs the symbols of one letter (first symbol in the LSB,
// 1 = dash) and reports letter and word boundaries from the released time.
// Ports:
//   Clock        : system clock (only clock)
//   Reset        : asynchronous active-high reset
//   tick         : one-cycle time-base strobe
//   unparsed     : raw key, asynchronous, 0 = pressed
//   dot / dash   : one-cycle pulse when a press is classified
//   letter_valid : one-cycle pulse when a letter closes
//   letter_code  : symbols of the closed letter, unused bits 0
//   letter_len   : number of symbols stored in the closed letter
//   overflow     : the closed letter had more presses than MAX_SYMBOLS
//   word_gap     : one-cycle pulse when a word gap is detected
// letter_code / letter_len / overflow hold until the next letter_valid.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int DASH_TICKS       = 3,
  parameter int LETTER_GAP_TICKS = 3,
  parameter int WORD_GAP_TICKS   = 7,
  parameter int MAX_SYMBOLS      = 5,
  parameter int CNT_W            = 8
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic                                 tick,
  input  logic                                 unparsed,
  output logic                                 dot,
  output logic                                 dash,
  output logic                                 letter_valid,
  output logic [MAX_SYMBOLS-1:0]               letter_code,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]     letter_len,
  output logic                                 overflow,
  output logic                                 word_gap
);

  localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LGAP_C   = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [CNT_W-1:0] WGAP_C   = CNT_W'(WORD_GAP_TICKS);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_SYMBOLS);

  // Key synchronisation (two stages, settles before the FSM sees it).
  logic key_sync_q;
  logic pressed;

  key_sync u_key_sync (
    .Clock    (Clock),
    .Reset    (Reset),
    .async_in (unparsed),
    .sync_out (key_sync_q)
  );

  assign pressed = ~key_sync_q;

  // Decoder state.
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [MAX_SYMBOLS-1:0] buf_code;
  logic [LEN_W-1:0]     buf_len;
  logic                 buf_ovf;

  // Combinational event decode.
  logic letter_hit;
  logic word_hit;
  logic release_ok;
  logic store_sym;
  logic dot_nxt, dash_nxt, lv_nxt, wg_nxt;

  // Saturating tick count as it would be after this edge.
  always_comb begin
    cnt_inc = cnt;
    if (tick && (cnt != CNT_MAX)) begin
      cnt_inc = cnt + CNT_W'(1);
    end
  end

  // Thresholds are detected on the tick that makes the count reach them,
  // so the registered pulse lands in the following cycle.
  assign letter_hit = (state == GAP)  && tick && (cnt_inc == LGAP_C);
  assign word_hit   = (state == WGAP) && tick && (cnt_inc == WGAP_C);

  // A release with a zero count is treated as a glitch.
  assign release_ok = (state == PRESS) && !pressed && (cnt != '0);

  // FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pressed) state_nxt = PRESS;
      end
      PRESS: begin
        if (!pressed) begin
          if (cnt == '0) begin
            state_nxt = (buf_len != '0) ? GAP : IDLE;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        // A press always wins the transition; the letter still closes below
        // if the threshold lands on the same cycle.
        if (pressed)         state_nxt = PRESS;
        else if (letter_hit) state_nxt = WGAP;
      end
      WGAP: begin
        if (pressed)       state_nxt = PRESS;
        else if (word_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // The counter restarts on every state change, except that the word gap
    // is timed from the release, so GAP->WGAP keeps counting. A release that
    // coincides with a tick therefore drops that tick.
    cnt_nxt = cnt_inc;
    if ((state_nxt != state) && !((state == GAP) && (state_nxt == WGAP))) begin
      cnt_nxt = '0;
    end
  end

  // FSM output logic.
  always_comb begin
    store_sym = (cnt >= DASH_C) ? SYM_DASH : SYM_DOT;
    dash_nxt  = release_ok && (store_sym == SYM_DASH);
    dot_nxt   = release_ok && (store_sym == SYM_DOT);
    lv_nxt    = letter_hit;
    wg_nxt    = word_hit && !pressed;
  end

  // Letter buffer. Symbols beyond capacity still pulse dot/dash but only
  // raise the overflow flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      buf_code <= '0;
      buf_len  <= '0;
      buf_ovf  <= 1'b0;
    end else if (letter_hit) begin
      buf_code <= '0;
      buf_len  <= '0;
      buf_ovf  <= 1'b0;
    end else if (release_ok) begin
      if (buf_len == MAX_LEN) begin
        buf_ovf <= 1'b1;
      end else begin
        buf_code <= buf_code | (MAX_SYMBOLS'(store_sym) << buf_len);
        buf_len  <= buf_len + LEN_W'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dot          <= 1'b0;
      dash         <= 1'b0;
      letter_valid <= 1'b0;
      word_gap     <= 1'b0;
      letter_code  <= '0;
      letter_len   <= '0;
      overflow     <= 1'b0;
    end else begin
      dot          <= dot_nxt;
      dash         <= dash_nxt;
      letter_valid <= lv_nxt;
      word_gap     <= wg_nxt;
      if (lv_nxt) begin
        letter_code <= buf_code;
        letter_len  <= buf_len;
        overflow    <= buf_ovf;
      end
    end
  end

endmodule
